// File: rtl/ir_scan_pi.sv
// IR line-sensor scanner with PI steering.
// Each pair is lit, settled, then its right and left channels are converted.
// The weighted right-minus-left difference feeds a PI loop that produces
// differential motor commands around a base speed.
module ir_scan_pi #(
  parameter int                 NUM_PAIRS  = 3,
  parameter int                 SETTLE_CYC = 4096,
  parameter int                 GAP_CYC    = 32,
  parameter logic [7:0]         PWM_DUTY   = 8'h8C,
  parameter int                 P_SHIFT    = 2,
  parameter int                 I_SHIFT    = 4,
  parameter logic signed [10:0] BASE_SPD   = 11'sd400
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     go,
  input  logic                     cnv_cmplt,
  input  logic [11:0]              a2d_res,
  output logic                     strt_cnv,
  output logic [2:0]               chnnl,
  output logic [NUM_PAIRS-1:0]     ir_en,
  output logic signed [10:0]       lft,
  output logic signed [10:0]       rht,
  output logic                     pi_vld
);

  // Timer must reach the larger of the two wait lengths.
  localparam int TW = $clog2((SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC) + 1;

  typedef enum logic [2:0] {
    IDLE, SETTLE, CNV_R, GAP, CNV_L, NEXT, PI_CALC, UPDATE
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [1:0]             pair_q, pair_d;
  logic signed [17:0]     accum_q, accum_d;
  logic signed [15:0]     integ_q, integ_d;
  logic signed [18:0]     corr_q, corr_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   strt_q, strt_d;
  logic [2:0]             chnnl_q, chnnl_d;
  logic                   pi_vld_q, pi_vld_d;
  logic signed [10:0]     lft_q, lft_d;
  logic signed [10:0]     rht_q, rht_d;

  logic [17:0]            a2d_sh;
  logic signed [18:0]     accum_x, integ_x, integ_sum, corr_new;
  logic signed [15:0]     integ_new;
  logic signed [19:0]     base_x, corr_x, lft_sum, rht_sum;
  logic                   pwm, emit_on;

  function automatic logic signed [15:0] sat16(input logic signed [18:0] v);
    if (v > 19'sd32767)       return 16'sh7FFF;
    else if (v < -19'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  function automatic logic signed [10:0] sat11(input logic signed [19:0] v);
    if (v > 20'sd1023)       return 11'sh3FF;
    else if (v < -20'sd1024) return 11'sh400;
    else                     return v[10:0];
  endfunction

  // Sample weighting: pair p counts 2^p; accumulator width leaves headroom.
  assign a2d_sh    = {6'd0, a2d_res} << pair_q;

  // PI arithmetic at 19 bits, integrator saturated to 16 bits.
  assign accum_x   = $signed({accum_q[17], accum_q});
  assign integ_x   = $signed({{3{integ_q[15]}}, integ_q});
  assign integ_sum = integ_x + (accum_x >>> I_SHIFT);
  assign integ_new = sat16(integ_sum);
  assign corr_new  = (accum_x >>> P_SHIFT) + $signed({{3{integ_new[15]}}, integ_new});

  // Motor command sums widened so saturation sees the true value.
  assign base_x  = $signed({{9{BASE_SPD[10]}}, BASE_SPD});
  assign corr_x  = $signed({corr_q[18], corr_q});
  assign lft_sum = base_x + corr_x;
  assign rht_sum = base_x - corr_x;

  // Emitter is PWM-gated and only lit while the active pair is being measured.
  assign pwm     = (cnt_q < PWM_DUTY);
  assign emit_on = pwm && ((state_q == SETTLE) || (state_q == CNV_R) ||
                           (state_q == GAP)    || (state_q == CNV_L));

  generate
    for (genvar gi = 0; gi < NUM_PAIRS; gi++) begin : g_ir_en
      assign ir_en[gi] = emit_on && (pair_q == 2'(gi));
    end
  endgenerate

  // Next-state and datapath; dropping go outside IDLE/UPDATE aborts without side effects.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    pair_d   = pair_q;
    accum_d  = accum_q;
    integ_d  = integ_q;
    corr_d   = corr_q;
    cnt_d    = cnt_q + 8'd1;
    strt_d   = 1'b0;
    chnnl_d  = chnnl_q;
    pi_vld_d = 1'b0;
    lft_d    = lft_q;
    rht_d    = rht_q;

    if (!go && (state_q != IDLE) && (state_q != UPDATE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (go) begin
            pair_d  = 2'd0;
            timer_d = '0;
            accum_d = '0;
            integ_d = '0;
            state_d = SETTLE;
          end
        end
        SETTLE: begin
          if (timer_q == TW'(SETTLE_CYC - 1)) begin
            strt_d  = 1'b1;
            chnnl_d = {pair_q, 1'b0};
            state_d = CNV_R;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        CNV_R: begin
          if (cnv_cmplt) begin
            accum_d = accum_q + $signed(a2d_sh);
            timer_d = '0;
            state_d = GAP;
          end
        end
        GAP: begin
          if (timer_q == TW'(GAP_CYC - 1)) begin
            strt_d  = 1'b1;
            chnnl_d = {pair_q, 1'b1};
            state_d = CNV_L;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        CNV_L: begin
          if (cnv_cmplt) begin
            accum_d = accum_q - $signed(a2d_sh);
            state_d = NEXT;
          end
        end
        NEXT: begin
          if (pair_q == 2'(NUM_PAIRS - 1)) begin
            state_d = PI_CALC;
          end else begin
            pair_d  = pair_q + 2'd1;
            timer_d = '0;
            state_d = SETTLE;
          end
        end
        PI_CALC: begin
          integ_d = integ_new;
          corr_d  = corr_new;
          state_d = UPDATE;
        end
        UPDATE: begin
          lft_d    = sat11(lft_sum);
          rht_d    = sat11(rht_sum);
          pi_vld_d = 1'b1;
          if (go) begin
            pair_d  = 2'd0;
            accum_d = '0;
            timer_d = '0;
            state_d = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      pair_q   <= '0;
      accum_q  <= '0;
      integ_q  <= '0;
      corr_q   <= '0;
      cnt_q    <= '0;
      strt_q   <= 1'b0;
      chnnl_q  <= '0;
      pi_vld_q <= 1'b0;
      lft_q    <= '0;
      rht_q    <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      pair_q   <= pair_d;
      accum_q  <= accum_d;
      integ_q  <= integ_d;
      corr_q   <= corr_d;
      cnt_q    <= cnt_d;
      strt_q   <= strt_d;
      chnnl_q  <= chnnl_d;
      pi_vld_q <= pi_vld_d;
      lft_q    <= lft_d;
      rht_q    <= rht_d;
    end
  end

  assign strt_cnv = strt_q;
  assign chnnl    = chnnl_q;
  assign pi_vld   = pi_vld_q;
  assign lft      = lft_q;
  assign rht      = rht_q;

endmodule

// File: doc/ir_scan_pi.md
IR_SCAN_PI -- requirements
Module: ir_scan_pi

Interface
REQ-001 Parameter NUM_PAIRS, default 3, number of IR sensor pairs scanned; legal range 1..4.
REQ-002 Parameter SETTLE_CYC, default 4096, cycles of IR illumination before the right-side conversion of each pair.
REQ-003 Parameter GAP_CYC, default 32, cycles between right-side completion and left-side start.
REQ-004 Parameter PWM_DUTY, default 8'h8C, IR emitter PWM duty.
REQ-005 Parameters P_SHIFT and I_SHIFT, defaults 2 and 4, arithmetic right-shift gains for the P and I terms.
REQ-006 Parameter BASE_SPD, default 11'sd400, signed base motor command.
REQ-007 clk  input  1  system clock; all logic on rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 go  input  1  level; high = run continuous scans; low = stop.
REQ-010 cnv_cmplt  input  1  single-cycle pulse from A2D; result valid.
REQ-011 a2d_res  input  12  unsigned A2D result; sampled only with cnv_cmplt.
REQ-012 strt_cnv  output  1  single-cycle request to start an A2D conversion.
REQ-013 chnnl  output  3  A2D mux select = 2*pair + side (side 0 = right, 1 = left).
REQ-014 ir_en  output  NUM_PAIRS  PWM-gated one-hot emitter enable for the active pair.
REQ-015 lft, rht  output  11 each  signed motor commands.
REQ-016 pi_vld  output  1  one-cycle pulse when lft/rht update.

Function
REQ-017 States: IDLE, SETTLE, CNV_R, GAP, CNV_L, NEXT, PI_CALC, UPDATE.
REQ-018 IDLE: on go=1, clear pair index, timer, accumulator and integrator; go to SETTLE.
REQ-019 SETTLE: timer increments; at timer==SETTLE_CYC-1 assert strt_cnv for one cycle with chnnl side 0; go to CNV_R.
REQ-020 CNV_R: on cnv_cmplt, accum += a2d_res << pair; clear timer; go to GAP.
REQ-021 GAP: at timer==GAP_CYC-1 assert strt_cnv for one cycle with chnnl side 1; go to CNV_L.
REQ-022 CNV_L: on cnv_cmplt, accum -= a2d_res << pair; go to NEXT.
REQ-023 NEXT: if pair==NUM_PAIRS-1 go to PI_CALC; else pair+1, clear timer, go to SETTLE.
REQ-024 Accumulator: 18-bit signed; it cannot overflow within the legal parameter range.
REQ-025 PI_CALC: integ = sat16(integ + (accum >>> I_SHIFT)); corr = (accum >>> P_SHIFT) + new integ, at 19-bit signed width.
REQ-026 UPDATE: lft = sat11(BASE_SPD + corr), rht = sat11(BASE_SPD - corr), saturating to -1024..1023.
REQ-027 UPDATE: pulse pi_vld; if go=1 clear pair, accum and timer and go to SETTLE, integ retained; else go to IDLE.
REQ-028 PWM: free-running 8-bit counter; pwm = (cnt < PWM_DUTY).
REQ-029 ir_en[pair] = pwm in SETTLE, CNV_R, GAP and CNV_L; all ir_en bits are 0 in every other state.
REQ-030 go=0 in any state other than IDLE or UPDATE aborts to IDLE on the next edge; no strt_cnv, no pi_vld, lft/rht hold.
REQ-031 cnv_cmplt outside CNV_R or CNV_L is ignored; a2d_res is never sampled without cnv_cmplt.
REQ-032 CNV_R and CNV_L wait indefinitely for cnv_cmplt; there is no timeout.
REQ-033 strt_cnv is never asserted on consecutive cycles.
REQ-034 Scan latency: go sampled in IDLE at edge k; first strt_cnv is high in cycle k+SETTLE_CYC.

Reset
REQ-035 While rst=1 on a rising edge: state=IDLE, timer, pair, accum, integ and PWM counter = 0, strt_cnv=0, ir_en=0, chnnl=0, pi_vld=0, lft=rht=0.
REQ-036 rst takes priority over every other input, including mid-conversion; a late cnv_cmplt after reset is ignored.

Verification
REQ-037 Reset: hold rst 2 cycles with go=1 -> all outputs 0, state IDLE; first strt_cnv 4096 cycles after rst release.
REQ-038 Balanced: all six conversions return 2048 -> accum 0; pi_vld pulses once; lft=rht=400; chnnl sequence 0,1,2,3,4,5.
REQ-039 Right-heavy: right=1000, left=0 for all pairs -> accum 7000, integ 437, corr 2187; lft=1023, rht=-1024.
REQ-040 Two back-to-back scans with right=100, left=0 -> accum 700; scan 1: integ 43, corr 218, lft=618, rht=182; scan 2: integ 86, corr 261, lft=661, rht=139.
REQ-041 Abort: drop go during GAP of pair 1 -> IDLE next cycle, ir_en=0, no further strt_cnv, no pi_vld, lft/rht unchanged.
REQ-042 Spurious: pulse cnv_cmplt with a2d_res=4095 during SETTLE -> accum unchanged, state stays SETTLE; PWM: ir_en high 140 of every 256 cycles in SETTLE.
